tluh_burst_adapter: RTL and testbench

Parametrised TL-UH to TL-UL burst adapter. It sits between a TL-UH host (crossbar or DMA port) and a single-beat TL-UL device.
- Multi-beat PutFullData/PutPartialData bursts and multi-beat Get responses are serialised into single-beat device accesses at incrementing addresses.
- One host transaction is in flight at a time.
- Generalises the fixed 32-bit TL-UH field set to configurable address, data, source and size widths, and adds burst handling.

---
 rtl/tluh_burst_adapter.sv | 219 +++++++++++++++++++++
 tb/tb_tluh_burst_adapter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tluh_burst_adapter.sv
`default_nettype none
// tluh_burst_adapter: bridges a TL-UH host to a single-beat TL-UL device.
// Multi-beat Get/Put bursts become word accesses at incrementing addresses, one transaction at a time.
module tluh_burst_adapter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int AIW     = 4,
    parameter int DIW     = 1,
    parameter int SZW     = 4,
    parameter int MaxSize = 6
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                h_a_valid_i,
    output logic                                h_a_ready_o,
    input  logic [3+SZW+AIW+AW+DW/8+DW-1:0]     h_a_i,
    output logic                                h_d_valid_o,
    input  logic                                h_d_ready_i,
    output logic [3+SZW+AIW+DIW+DW+1-1:0]       h_d_o,
    output logic                                dev_a_valid_o,
    input  logic                                dev_a_ready_i,
    output logic [3+SZW+AIW+AW+DW/8+DW-1:0]     dev_a_o,
    input  logic                                dev_d_valid_i,
    output logic                                dev_d_ready_o,
    input  logic [3+SZW+AIW+DIW+DW+1-1:0]       dev_d_i,
    output logic                                proto_err_o
);
    localparam int DBW   = DW / 8;
    localparam int OffW  = $clog2(DBW);
    localparam int BeatW = MaxSize - OffW + 1;
    localparam int DWID  = 3 + SZW + AIW + DIW + DW + 1;
    localparam int DSZLO = AIW + DIW + DW + 1;

    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    typedef enum logic [2:0] {IDLE, REQ, RSP, PNEXT, ERR} state_t;
    state_t state_q, state_d;

    logic [2:0]       a_op;
    logic [SZW-1:0]   a_size;
    logic [AIW-1:0]   a_src;
    logic [AW-1:0]    a_addr;
    logic [DBW-1:0]   a_mask;
    logic [DW-1:0]    a_data;
    assign {a_op, a_size, a_src, a_addr, a_mask, a_data} = h_a_i;

    logic             live_q, proto_q, err_q;
    logic [2:0]       op_q;
    logic [SZW-1:0]   size_q;
    logic [AIW-1:0]   src_q;
    logic [AW-1:0]    addr_q;
    logic [DBW-1:0]   mask_q;
    logic [DW-1:0]    data_q;
    logic [BeatW-1:0] k_q;

    // Oversized requests are clamped before the alignment check and beat count.
    logic             oversize, misaligned;
    logic [SZW-1:0]   size_c;
    assign oversize   = a_size > SZW'(MaxSize);
    assign size_c     = oversize ? SZW'(MaxSize) : a_size;
    assign misaligned = |(a_addr & ((AW'(1) << size_c) - AW'(1)));

    logic             multi, is_last, is_get;
    logic [BeatW-1:0] last_k;
    assign multi   = size_q > SZW'(OffW);
    assign last_k  = multi ? (BeatW'(1) << (size_q - SZW'(OffW))) - BeatW'(1) : '0;
    assign is_last = (k_q == last_k);
    assign is_get  = (op_q == OP_GET);

    logic [AW-1:0]    base, req_addr;
    logic [SZW-1:0]   req_size;
    assign base     = {addr_q[AW-1:OffW], {OffW{1'b0}}};
    assign req_addr = multi ? base + (AW'(k_q) << OffW) : addr_q;
    assign req_size = multi ? SZW'(OffW) : size_q;

    logic [DWID-1:0]  fwd, err_rsp;
    always_comb begin
        fwd = dev_d_i;
        fwd[DSZLO +: SZW] = size_q;
        if (!is_get) begin
            fwd[0] = err_q | dev_d_i[0];
        end
    end
    assign err_rsp = {(is_get ? OP_ACK_DATA : OP_ACK), size_q, src_q, {DIW{1'b0}}, {DW{1'b0}}, 1'b1};

    logic a_fire, dd_fire, hd_fire;
    assign a_fire  = h_a_valid_i & h_a_ready_o;
    assign dd_fire = dev_d_valid_i & dev_d_ready_o;
    assign hd_fire = h_d_valid_o & h_d_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        h_a_ready_o   = 1'b0;
        h_d_valid_o   = 1'b0;
        h_d_o         = '0;
        dev_a_valid_o = 1'b0;
        dev_a_o       = '0;
        dev_d_ready_o = 1'b0;
        case (state_q)
            IDLE: begin
                h_a_ready_o = live_q;
                if (a_fire) begin
                    state_d = misaligned ? ERR : REQ;
                end
            end
            REQ: begin
                dev_a_valid_o = 1'b1;
                dev_a_o       = {op_q, req_size, src_q, req_addr, mask_q, data_q};
                if (dev_a_ready_i) begin
                    state_d = RSP;
                end
            end
            RSP: begin
                if (is_get || is_last) begin
                    h_d_valid_o   = dev_d_valid_i;
                    h_d_o         = fwd;
                    dev_d_ready_o = h_d_ready_i;
                    if (dd_fire) begin
                        state_d = (is_last) ? IDLE : REQ;
                    end
                end else begin
                    // Intermediate Put acks are absorbed; only their error bit survives.
                    dev_d_ready_o = 1'b1;
                    if (dev_d_valid_i) begin
                        state_d = PNEXT;
                    end
                end
            end
            PNEXT: begin
                h_a_ready_o = 1'b1;
                if (h_a_valid_i) begin
                    state_d = REQ;
                end
            end
            ERR: begin
                if (!is_get && !is_last) begin
                    h_a_ready_o = 1'b1;
                end else begin
                    h_d_valid_o = 1'b1;
                    h_d_o       = err_rsp;
                    if (h_d_ready_i && is_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            live_q  <= 1'b0;
            proto_q <= 1'b0;
            err_q   <= 1'b0;
            op_q    <= '0;
            size_q  <= '0;
            src_q   <= '0;
            addr_q  <= '0;
            mask_q  <= '0;
            data_q  <= '0;
            k_q     <= '0;
        end else begin
            live_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (a_fire) begin
                        op_q   <= a_op;
                        size_q <= size_c;
                        src_q  <= a_src;
                        addr_q <= a_addr;
                        mask_q <= a_mask;
                        data_q <= a_data;
                        k_q    <= '0;
                        err_q  <= 1'b0;
                        if (oversize) begin
                            proto_q <= 1'b1;
                        end
                    end
                end
                RSP: begin
                    if (dd_fire) begin
                        if (is_get) begin
                            k_q <= k_q + BeatW'(1);
                        end else if (!is_last) begin
                            err_q <= err_q | dev_d_i[0];
                        end
                    end
                end
                PNEXT: begin
                    if (a_fire) begin
                        mask_q <= a_mask;
                        data_q <= a_data;
                        k_q    <= k_q + BeatW'(1);
                    end
                end
                ERR: begin
                    if (a_fire || (is_get && hd_fire)) begin
                        k_q <= k_q + BeatW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign proto_err_o = proto_q;

endmodule
`default_nettype wire

// File: tb/tb_tluh_burst_adapter.sv
`default_nettype none
// tb_tluh_burst_adapter: directed bench for the burst adapter against a zero-wait device model.
// Device Get data is 0xD0000000 | address, so expected beats follow from the request address.
module tb_tluh_burst_adapter;
    localparam int AWID = 79;
    localparam int DWID = 45;

    logic            clk_i = 1'b0;
    logic            rst_ni = 1'b0;
    logic            h_a_valid_i = 1'b0;
    logic            h_a_ready_o;
    logic [AWID-1:0] h_a_i = '0;
    logic            h_d_valid_o;
    logic            h_d_ready_i = 1'b1;
    logic [DWID-1:0] h_d_o;
    logic            dev_a_valid_o;
    logic            dev_a_ready_i = 1'b1;
    logic [AWID-1:0] dev_a_o;
    logic            dev_d_valid_i = 1'b0;
    logic            dev_d_ready_o;
    logic [DWID-1:0] dev_d_i = '0;
    logic            proto_err_o;

    always #5 clk_i = ~clk_i;

    tluh_burst_adapter dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .h_a_valid_i  (h_a_valid_i),
        .h_a_ready_o  (h_a_ready_o),
        .h_a_i        (h_a_i),
        .h_d_valid_o  (h_d_valid_o),
        .h_d_ready_i  (h_d_ready_i),
        .h_d_o        (h_d_o),
        .dev_a_valid_o(dev_a_valid_o),
        .dev_a_ready_i(dev_a_ready_i),
        .dev_a_o      (dev_a_o),
        .dev_d_valid_i(dev_d_valid_i),
        .dev_d_ready_o(dev_d_ready_o),
        .dev_d_i      (dev_d_i),
        .proto_err_o  (proto_err_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [AWID-1:0] dreq_q[$];
    int              dreq_rsp[$];
    logic [DWID-1:0] hrsp_q[$];
    int              hrsp_nreq[$];
    int              dev_rsp_cnt = 0;
    int              err_idx = -1;
    logic            a_fire_s = 1'b0;
    logic            d_fire_s = 1'b0;
    logic [AWID-1:0] a_pay_s = '0;
    logic            pay_get;

    always @(posedge clk_i) begin
        a_fire_s = rst_ni && dev_a_valid_o && dev_a_ready_i;
        d_fire_s = rst_ni && dev_d_valid_i && dev_d_ready_o;
        a_pay_s  = dev_a_o;
        if (a_fire_s) begin
            dreq_q.push_back(dev_a_o);
            dreq_rsp.push_back(dev_rsp_cnt);
        end
        if (d_fire_s) dev_rsp_cnt++;
        if (rst_ni && h_d_valid_o && h_d_ready_i) begin
            hrsp_q.push_back(h_d_o);
            hrsp_nreq.push_back(dreq_q.size());
        end
    end

    always @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dev_d_valid_i = 1'b0;
            dev_d_i       = '0;
        end else begin
            if (d_fire_s) dev_d_valid_i = 1'b0;
            if (a_fire_s) begin
                pay_get = (a_pay_s[78:76] == 3'd4);
                dev_d_i = {(pay_get ? 3'd1 : 3'd0), a_pay_s[75:72], a_pay_s[71:68], 1'b0,
                           (pay_get ? (32'hD000_0000 | a_pay_s[67:36]) : 32'h0),
                           ((dreq_q.size() - 1) == err_idx)};
                dev_d_valid_i = 1'b1;
            end
        end
    end

    task automatic clear_logs();
        dreq_q.delete();
        dreq_rsp.delete();
        hrsp_q.delete();
        hrsp_nreq.delete();
        dev_rsp_cnt = 0;
        err_idx = -1;
    endtask

    task automatic send_a(input logic [2:0] op, input logic [3:0] sz, input logic [3:0] src,
                          input logic [31:0] addr, input logic [3:0] mask, input logic [31:0] data);
        int cnt = 0;
        h_a_i = {op, sz, src, addr, mask, data};
        h_a_valid_i = 1'b1;
        while (!h_a_ready_o && cnt < 200) begin
            @(negedge clk_i);
            cnt++;
        end
        if (!h_a_ready_o) check("a_accept_timeout", 0, 1);
        @(negedge clk_i);
        h_a_valid_i = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input string tag);
        int cnt = 0;
        while (hrsp_q.size() < n && cnt < 500) begin
            @(negedge clk_i);
            cnt++;
        end
        check({tag, "_rsp_arrived"}, hrsp_q.size() >= n, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AWID-1:0] a;
        logic [DWID-1:0] d;

        repeat (2) @(negedge clk_i);
        check("rst_h_a_ready", h_a_ready_o, 0);
        check("rst_h_d_valid", h_d_valid_o, 0);
        check("rst_dev_a_valid", dev_a_valid_o, 0);
        check("rst_dev_d_ready", dev_d_ready_o, 0);
        check("rst_proto_err", proto_err_o, 0);
        check("rst_h_d_o", h_d_o, 0);
        check("rst_dev_a_o", dev_a_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("h_a_ready_after_rst", h_a_ready_o, 1);

        // Single-beat Get, byte size, unaligned-to-word address.
        clear_logs();
        send_a(3'd4, 4'd0, 4'd3, 32'h1003, 4'b1000, 32'h0);
        check("t1_dev_a_latency", dev_a_valid_o, 1);
        wait_rsp(1, "t1");
        check("t1_ready_next", h_a_ready_o, 1);
        check("t1_nreq", dreq_q.size(), 1);
        a = dreq_q[0];
        check("t1_req_addr", a[67:36], 32'h1003);
        check("t1_req_size", a[75:72], 0);
        check("t1_req_op", a[78:76], 4);
        d = hrsp_q[0];
        check("t1_rsp_op", d[44:42], 1);
        check("t1_rsp_size", d[41:38], 0);
        check("t1_rsp_src", d[37:34], 3);
        check("t1_rsp_data", d[32:1], 32'hD000_1003);
        check("t1_rsp_err", d[0], 0);

        // Four-beat Get burst.
        clear_logs();
        send_a(3'd4, 4'd4, 4'd5, 32'h100, 4'hF, 32'h0);
        wait_rsp(4, "t2");
        repeat (3) @(negedge clk_i);
        check("t2_nreq", dreq_q.size(), 4);
        check("t2_nrsp", hrsp_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            a = dreq_q[i];
            d = hrsp_q[i];
            check($sformatf("t2_req%0d_addr", i), a[67:36], 32'h100 + 4 * i);
            check($sformatf("t2_req%0d_size", i), a[75:72], 2);
            check($sformatf("t2_req%0d_after_rsp", i), dreq_rsp[i], i);
            check($sformatf("t2_rsp%0d_size", i), d[41:38], 4);
            check($sformatf("t2_rsp%0d_data", i), d[32:1], 32'hD000_0100 + 4 * i);
        end

        // Two-beat PutFullData.
        clear_logs();
        send_a(3'd0, 4'd3, 4'd2, 32'h200, 4'hF, 32'hA5A5_A5A5);
        send_a(3'd0, 4'd3, 4'd2, 32'h200, 4'hF, 32'h5A5A_5A5A);
        wait_rsp(1, "t3");
        repeat (4) @(negedge clk_i);
        check("t3_nreq", dreq_q.size(), 2);
        check("t3_nrsp", hrsp_q.size(), 1);
        a = dreq_q[0];
        check("t3_req0_addr", a[67:36], 32'h200);
        check("t3_req0_data", a[31:0], 32'hA5A5_A5A5);
        check("t3_req0_mask", a[35:32], 4'hF);
        check("t3_req0_op", a[78:76], 0);
        a = dreq_q[1];
        check("t3_req1_addr", a[67:36], 32'h204);
        check("t3_req1_data", a[31:0], 32'h5A5A_5A5A);
        check("t3_req1_size", a[75:72], 2);
        d = hrsp_q[0];
        check("t3_rsp_op", d[44:42], 0);
        check("t3_rsp_size", d[41:38], 3);
        check("t3_rsp_src", d[37:34], 2);
        check("t3_rsp_err", d[0], 0);
        check("t3_rsp_after_reqs", hrsp_nreq[0], 2);

        // Four-beat Put with a device error on an intermediate beat.
        clear_logs();
        err_idx = 2;
        for (int i = 0; i < 4; i++) send_a(3'd1, 4'd4, 4'd7, 32'h300, 4'hF, 32'h1000 + i);
        wait_rsp(1, "t4");
        repeat (4) @(negedge clk_i);
        check("t4_nreq", dreq_q.size(), 4);
        check("t4_nrsp", hrsp_q.size(), 1);
        a = dreq_q[3];
        check("t4_req3_addr", a[67:36], 32'h30C);
        check("t4_req3_data", a[31:0], 32'h1003);
        d = hrsp_q[0];
        check("t4_rsp_err", d[0], 1);
        check("t4_rsp_size", d[41:38], 4);

        // Misaligned Get: error beats, no device traffic.
        clear_logs();
        send_a(3'd4, 4'd3, 4'd6, 32'h204, 4'hF, 32'h0);
        wait_rsp(2, "t5g");
        repeat (3) @(negedge clk_i);
        check("t5g_nreq", dreq_q.size(), 0);
        check("t5g_nrsp", hrsp_q.size(), 2);
        for (int i = 0; i < 2; i++) begin
            d = hrsp_q[i];
            check($sformatf("t5g_rsp%0d_op", i), d[44:42], 1);
            check($sformatf("t5g_rsp%0d_size", i), d[41:38], 3);
            check($sformatf("t5g_rsp%0d_src", i), d[37:34], 6);
            check($sformatf("t5g_rsp%0d_data", i), d[32:1], 0);
            check($sformatf("t5g_rsp%0d_err", i), d[0], 1);
        end

        // Misaligned Put: both beats absorbed, one error ack.
        clear_logs();
        send_a(3'd0, 4'd3, 4'd6, 32'h204, 4'hF, 32'h11);
        send_a(3'd0, 4'd3, 4'd6, 32'h204, 4'hF, 32'h22);
        wait_rsp(1, "t5p");
        repeat (4) @(negedge clk_i);
        check("t5p_nreq", dreq_q.size(), 0);
        check("t5p_nrsp", hrsp_q.size(), 1);
        d = hrsp_q[0];
        check("t5p_rsp_op", d[44:42], 0);
        check("t5p_rsp_err", d[0], 1);
        check("t5p_h_a_ready", h_a_ready_o, 1);

        // Oversized Get clamps to the largest burst and flags a protocol error.
        clear_logs();
        send_a(3'd4, 4'd7, 4'd1, 32'h400, 4'hF, 32'h0);
        check("t6_proto_err", proto_err_o, 1);
        wait_rsp(16, "t6");
        repeat (3) @(negedge clk_i);
        check("t6_nreq", dreq_q.size(), 16);
        check("t6_nrsp", hrsp_q.size(), 16);
        a = dreq_q[15];
        check("t6_req15_addr", a[67:36], 32'h43C);
        d = hrsp_q[15];
        check("t6_rsp15_data", d[32:1], 32'hD000_043C);

        // Reset in the middle of a Get burst.
        clear_logs();
        send_a(3'd4, 4'd4, 4'd9, 32'h500, 4'hF, 32'h0);
        wait_rsp(1, "t7");
        check("t7_proto_sticky", proto_err_o, 1);
        check("t7_pre_rst_dev_a_valid", dev_a_valid_o, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t7_rst_h_a_ready", h_a_ready_o, 0);
        check("t7_rst_h_d_valid", h_d_valid_o, 0);
        check("t7_rst_dev_a_valid", dev_a_valid_o, 0);
        check("t7_rst_dev_d_ready", dev_d_ready_o, 0);
        check("t7_rst_proto_err", proto_err_o, 0);
        check("t7_rst_h_d_o", h_d_o, 0);
        check("t7_rst_dev_a_o", dev_a_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("t7_h_a_ready_after_rst", h_a_ready_o, 1);

        // Word-sized Get is a single beat at the original address and size.
        clear_logs();
        send_a(3'd4, 4'd2, 4'd4, 32'h600, 4'hF, 32'h0);
        wait_rsp(1, "t8");
        repeat (3) @(negedge clk_i);
        check("t8_nreq", dreq_q.size(), 1);
        a = dreq_q[0];
        check("t8_req_addr", a[67:36], 32'h600);
        d = hrsp_q[0];
        check("t8_rsp_data", d[32:1], 32'hD000_0600);
        check("t8_nrsp", hrsp_q.size(), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
